// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: forwarding selects,
// load-use / branch stalls, D-stage flush and the multicycle MULT/DIV hold of Execute.
module hazard_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic       Branch_D,
  input  logic       Jr_D,
  input  logic       J_D,
  input  logic       PCSrc_D,
  input  logic [4:0] Rs_E,
  input  logic [4:0] Rt_E,
  input  logic [4:0] WriteReg_E,
  input  logic [4:0] WriteReg_M,
  input  logic [4:0] WriteReg_W,
  input  logic       RegWrite_E,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       MemtoReg_E,
  input  logic       MemtoReg_M,
  input  logic       mdu_start_E,
  input  logic       mdu_div_E,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       EN_DE,
  output logic       CLR_DE,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       ForwardA_D,
  output logic       ForwardB_D,
  output logic       mdu_busy,
  output logic       mdu_done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  // BUSY counts N-3 down to 0, so IDLE + BUSY + DONE add up to exactly N cycles.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 3);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 3);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_c;
  logic             n_is_two;
  logic             lwstall, branchstall, hit_e, hit_m;

  function automatic logic [1:0] fwd_e(input logic [4:0] src, input logic rw_m,
                                       input logic [4:0] wr_m, input logic rw_w,
                                       input logic [4:0] wr_w);
    if (src != 5'd0 && rw_m && wr_m == src)      return 2'b10;
    else if (src != 5'd0 && rw_w && wr_w == src) return 2'b01;
    else                                         return 2'b00;
  endfunction

  // Does a writer of register dst feed a D-stage source? Jr only reads Rs.
  function automatic logic d_src_hit(input logic [4:0] dst, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic br, input logic jr);
    return (dst != 5'd0) && ((br && (dst == rs || dst == rt)) || (jr && dst == rs));
  endfunction

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign n_is_two = mdu_div_E ? (DIV_CYCLES == 2) : (MULT_CYCLES == 2);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdu_start_E) begin
          busy_c = 1'b1;
          if (n_is_two) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = mdu_div_E ? DIV_LOAD : MULT_LOAD;
          end
        end
      end
      BUSY: begin
        busy_c = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lwstall     = MemtoReg_E && WriteReg_E != 5'd0 &&
                       (WriteReg_E == Rs_D || WriteReg_E == Rt_D);
  assign hit_e       = RegWrite_E && d_src_hit(WriteReg_E, Rs_D, Rt_D, Branch_D, Jr_D);
  assign hit_m       = MemtoReg_M && d_src_hit(WriteReg_M, Rs_D, Rt_D, Branch_D, Jr_D);
  assign branchstall = (Branch_D || Jr_D) && (hit_e || hit_m);

  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    EN_DE      = 1'b1;
    CLR_DE     = 1'b0;
    mdu_busy   = busy_c;
    mdu_done   = (state_q == DONE);
    ForwardA_E = fwd_e(Rs_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
    ForwardB_E = fwd_e(Rt_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
    ForwardA_D = Rs_D != 5'd0 && RegWrite_M && WriteReg_M == Rs_D;
    ForwardB_D = Rt_D != 5'd0 && RegWrite_M && WriteReg_M == Rt_D;
    // The MDU hold keeps E intact; a pending load-use bubble waits until DONE.
    if (busy_c) begin
      StallF = 1'b1;
      StallD = 1'b1;
      EN_DE  = 1'b0;
    end else if (lwstall || branchstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      EN_DE  = 1'b0;
      CLR_DE = 1'b1;
    end
    FlushD = (PCSrc_D || J_D || Jr_D) && !StallD;
    if (!rst_n) begin
      StallF     = 1'b0;
      StallD     = 1'b0;
      FlushD     = 1'b0;
      EN_DE      = 1'b0;
      CLR_DE     = 1'b1;
      ForwardA_E = 2'b00;
      ForwardB_E = 2'b00;
      ForwardA_D = 1'b0;
      ForwardB_D = 1'b0;
      mdu_busy   = 1'b0;
      mdu_done   = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: constant vector table, hand-written
// multicycle sequences and a randomized run against a cycle-position reference model.
module tb_hazard_controller;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;

  typedef struct packed {
    logic [4:0] rs_d, rt_d;
    logic       branch_d, jr_d, j_d, pcsrc_d;
    logic [4:0] rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, start, div;
  } in_t;

  typedef struct {
    in_t         v;
    logic [12:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic Branch_D, Jr_D, J_D, PCSrc_D, RegWrite_E, RegWrite_M, RegWrite_W;
  logic MemtoReg_E, MemtoReg_M, mdu_start_E, mdu_div_E;
  logic StallF, StallD, FlushD, EN_DE, CLR_DE, ForwardA_D, ForwardB_D, mdu_busy, mdu_done;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic [12:0] outs;

  int total = 0;
  int bad   = 0;

  // Reference MDU state: cycles already spent in E by the current op, and its length.
  int   pos = 0;
  int   n_len = 0;
  in_t  cur_v = '0;
  bit   cur_rst = 1'b0;
  vec_t tbl[$];

  hazard_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Branch_D(Branch_D), .Jr_D(Jr_D), .J_D(J_D),
    .PCSrc_D(PCSrc_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
    .mdu_start_E(mdu_start_E), .mdu_div_E(mdu_div_E),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .EN_DE(EN_DE), .CLR_DE(CLR_DE),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );

  // Bits: 12 StallF, 11 StallD, 10 FlushD, 9 EN_DE, 8 CLR_DE, 7:6 FwdA_E, 5:4 FwdB_E,
  // 3 FwdA_D, 2 FwdB_D, 1 busy, 0 done.
  assign outs = {StallF, StallD, FlushD, EN_DE, CLR_DE, ForwardA_E, ForwardB_E,
                 ForwardA_D, ForwardB_D, mdu_busy, mdu_done};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] x, input in_t v);
    if (x == 0) return 2'b00;
    if (v.rw_m && v.wr_m == x) return 2'b10;
    if (v.rw_w && v.wr_w == x) return 2'b01;
    return 2'b00;
  endfunction

  // Position of the current cycle within the MDU op (0 = no op) and that op's length.
  function automatic int cur_pos(input in_t v);
    if (pos != 0) return pos + 1;
    return v.start ? 1 : 0;
  endfunction

  function automatic int cur_len(input in_t v);
    if (pos != 0) return n_len;
    return v.div ? DIV_N : MULT_N;
  endfunction

  function automatic logic [12:0] model_out(input in_t v, input bit rstn);
    int  p, len;
    bit  busy, done, lw, hit_e, hit_m, bs, stall;
    if (!rstn) return 13'h100;
    p     = cur_pos(v);
    len   = cur_len(v);
    busy  = (p != 0) && (p < len);
    done  = (p != 0) && (p == len);
    lw    = v.m2r_e && v.wr_e != 0 && (v.wr_e == v.rs_d || v.wr_e == v.rt_d);
    hit_e = v.rw_e && v.wr_e != 0 &&
            ((v.branch_d && (v.wr_e == v.rs_d || v.wr_e == v.rt_d)) || (v.jr_d && v.wr_e == v.rs_d));
    hit_m = v.m2r_m && v.wr_m != 0 &&
            ((v.branch_d && (v.wr_m == v.rs_d || v.wr_m == v.rt_d)) || (v.jr_d && v.wr_m == v.rs_d));
    bs    = hit_e || hit_m;
    stall = busy || lw || bs;
    return {stall, stall, (v.pcsrc_d || v.j_d || v.jr_d) && !stall, !stall,
            !busy && (lw || bs), ref_fwd(v.rs_e, v), ref_fwd(v.rt_e, v),
            v.rs_d != 0 && v.rw_m && v.wr_m == v.rs_d,
            v.rt_d != 0 && v.rw_m && v.wr_m == v.rt_d, busy, done};
  endfunction

  task automatic model_tick();
    int p, len;
    p   = cur_pos(cur_v);
    len = cur_len(cur_v);
    if (!cur_rst || p == 0 || p == len) pos = 0;
    else begin
      pos   = p;
      n_len = len;
    end
  endtask

  // One cycle: advance the model over the previous cycle, apply new inputs, compare.
  task automatic drive(input in_t v, input bit rstn, input string name);
    @(posedge clk);
    model_tick();
    @(negedge clk);
    cur_v = v; cur_rst = rstn;
    rst_n = rstn;
    Rs_D = v.rs_d; Rt_D = v.rt_d; Branch_D = v.branch_d; Jr_D = v.jr_d; J_D = v.j_d;
    PCSrc_D = v.pcsrc_d; Rs_E = v.rs_e; Rt_E = v.rt_e;
    WriteReg_E = v.wr_e; WriteReg_M = v.wr_m; WriteReg_W = v.wr_w;
    RegWrite_E = v.rw_e; RegWrite_M = v.rw_m; RegWrite_W = v.rw_w;
    MemtoReg_E = v.m2r_e; MemtoReg_M = v.m2r_m; mdu_start_E = v.start; mdu_div_E = v.div;
    #1;
    check(name, 16'(outs), 16'(model_out(v, rstn)));
  endtask

  task automatic add(input in_t v, input logic [12:0] e, input string nm);
    vec_t t;
    t.v = v; t.exp = e; t.name = nm;
    tbl.push_back(t);
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.rs_d = 5'($urandom_range(0, 3)); v.rt_d = 5'($urandom_range(0, 3));
    v.rs_e = 5'($urandom_range(0, 3)); v.rt_e = 5'($urandom_range(0, 3));
    v.wr_e = 5'($urandom_range(0, 3)); v.wr_m = 5'($urandom_range(0, 3));
    v.wr_w = 5'($urandom_range(0, 3));
    v.branch_d = 1'($urandom); v.jr_d = 1'($urandom_range(0, 3) == 0);
    v.j_d = 1'($urandom_range(0, 3) == 0); v.pcsrc_d = 1'($urandom);
    v.rw_e = 1'($urandom); v.rw_m = 1'($urandom); v.rw_w = 1'($urandom);
    v.m2r_e = 1'($urandom); v.m2r_m = 1'($urandom);
    v.start = 1'($urandom_range(0, 7) == 0); v.div = 1'($urandom_range(0, 3) == 0);
    return v;
  endfunction

  initial begin
    in_t v, z;
    z = '0;

    drive(z, 1'b0, "reset_a");
    check("reset_state", 16'(outs), 16'h0100);
    drive(z, 1'b1, "idle");
    check("idle_state", 16'(outs), 16'h0200);

    // Constant vectors, MDU idle throughout.
    v = z; v.rs_e = 5; v.rw_m = 1; v.wr_m = 5; v.rw_w = 1; v.wr_w = 5; add(v, 13'h280, "fwdA_M");
    v.wr_m = 6;                                                        add(v, 13'h240, "fwdA_W");
    v = z; v.rw_m = 1; v.rw_w = 1;                                     add(v, 13'h200, "fwd_r0");
    v = z; v.rt_e = 7; v.rw_m = 1; v.wr_m = 7; v.rw_w = 1; v.wr_w = 7; add(v, 13'h220, "fwdB_M");
    v = z; v.m2r_e = 1; v.rw_e = 1; v.wr_e = 8; v.rt_d = 8;            add(v, 13'h1900, "loaduse");
    v = z; v.m2r_e = 1; v.rw_e = 1;                                    add(v, 13'h200, "lw_r0");
    v = z; v.branch_d = 1; v.rs_d = 3; v.rw_e = 1; v.wr_e = 3; v.pcsrc_d = 1;
    add(v, 13'h1900, "br_stall");
    v = z; v.branch_d = 1; v.rs_d = 3; v.rw_m = 1; v.wr_m = 3; v.pcsrc_d = 1;
    add(v, 13'h608, "br_fwd_flush");
    v = z; v.jr_d = 1; v.rs_d = 1; v.rt_d = 4; v.m2r_m = 1; v.rw_m = 1; v.wr_m = 4;
    add(v, 13'h604, "jr_rt_nohaz");
    v = z; v.j_d = 1;                                                  add(v, 13'h600, "jump_flush");
    v = z; v.branch_d = 1; v.rt_d = 9; v.m2r_m = 1; v.rw_m = 1; v.wr_m = 9;
    add(v, 13'h1904, "br_load_m");
    v = z; v.branch_d = 1; v.rw_e = 1;                                 add(v, 13'h200, "br_r0");
    foreach (tbl[i]) begin
      drive(tbl[i].v, 1'b1, tbl[i].name);
      check({tbl[i].name, "_tbl"}, 16'(outs), 16'(tbl[i].exp));
    end

    // Load-use: one bubble, then the load sits in M and E is enabled again.
    v = z; v.m2r_e = 1; v.rw_e = 1; v.wr_e = 8; v.rt_d = 8;
    drive(v, 1'b1, "lu_c1");
    check("lu_c1_clr", 16'(CLR_DE), 16'd1);
    v = z; v.m2r_m = 1; v.rw_m = 1; v.wr_m = 8; v.rt_d = 8;
    drive(v, 1'b1, "lu_c2");
    check("lu_c2_en", 16'(EN_DE), 16'd1);

    // Branch: stall with no flush, then forward from M and flush.
    v = z; v.branch_d = 1; v.rs_d = 3; v.rw_e = 1; v.wr_e = 3;
    drive(v, 1'b1, "br_c1");
    check("br_c1_flush", 16'({FlushD, StallD}), 16'b01);
    v = z; v.branch_d = 1; v.rs_d = 3; v.rw_m = 1; v.wr_m = 3; v.pcsrc_d = 1;
    drive(v, 1'b1, "br_c2");
    check("br_c2_fwd_flush", 16'({ForwardA_D, FlushD}), 16'b11);

    // MULT alongside a load-use hazard: hold for 3 cycles, bubble on DONE.
    v = z; v.start = 1; v.m2r_e = 1; v.wr_e = 2; v.rs_d = 2;
    for (int i = 1; i <= MULT_N; i++) begin
      drive(v, 1'b1, "mult_lu");
      if (i < MULT_N) check("mult_lu_hold", 16'({mdu_busy, mdu_done, EN_DE, CLR_DE}), 16'b1000);
      else            check("mult_lu_done", 16'({mdu_busy, mdu_done, EN_DE, CLR_DE}), 16'b0101);
    end

    // Plain MULT, then back-to-back DIV.
    v = z; v.start = 1;
    for (int i = 1; i <= MULT_N; i++) begin
      drive(v, 1'b1, "mult");
      if (i < MULT_N) check("mult_hold", 16'({mdu_busy, mdu_done, EN_DE, CLR_DE}), 16'b1000);
      else            check("mult_done", 16'({mdu_busy, mdu_done, EN_DE, CLR_DE}), 16'b0110);
    end
    v.div = 1;
    for (int i = 1; i <= DIV_N; i++) begin
      drive(v, 1'b1, "div");
      if (i < DIV_N) check("div_hold", 16'({mdu_busy, mdu_done, EN_DE}), 16'b100);
      else           check("div_done", 16'({mdu_busy, mdu_done, EN_DE}), 16'b011);
    end
    drive(z, 1'b1, "after_div");
    check("after_div_idle", 16'({mdu_busy, EN_DE}), 16'b01);

    // Reset at cycle 10 of a DIV aborts it.
    v = z; v.start = 1; v.div = 1;
    for (int i = 1; i < 10; i++) drive(v, 1'b1, "div_pre_rst");
    drive(v, 1'b0, "div_rst");
    check("div_rst_outs", 16'({StallF, StallD, EN_DE, CLR_DE, mdu_busy}), 16'b00010);
    drive(z, 1'b1, "div_rst_rel");
    check("div_rst_rel", 16'({mdu_busy, mdu_done, EN_DE}), 16'b001);

    // Randomized run against the reference model, with occasional resets.
    for (int i = 0; i < 3000; i++)
      drive(rand_in(), ($urandom_range(0, 63) != 0), "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Drives the EN/CLR controls of the Decode/Execute pipeline register, the F and D stage stalls, and the D-stage flush.
- Generates forwarding selects for the E-stage ALU and the D-stage branch comparator.
- Sequences multicycle MULT/DIV operations by holding the Execute stage for a fixed number of cycles.

Parameters:
- MULT_CYCLES, 4: total cycles a MULT instruction occupies E; must be >= 2.
- DIV_CYCLES, 32: total cycles a DIV instruction occupies E; must be >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- Rs_D, Rt_D  in  5 each  source registers of the instruction in D
- Branch_D, Jr_D, J_D  in  1 each  branch / jump-register / jump decoded in D
- PCSrc_D  in  1  branch resolved taken in D
- Rs_E, Rt_E  in  5 each  source registers in E
- WriteReg_E, WriteReg_M, WriteReg_W  in  5 each  destination registers per stage
- RegWrite_E, RegWrite_M, RegWrite_W  in  1 each  register write enables per stage
- MemtoReg_E, MemtoReg_M  in  1 each  load in E / M
- mdu_start_E  in  1  multicycle MDU instruction present in E
- mdu_div_E  in  1  1 = DIV, 0 = MULT (valid with mdu_start_E)
- StallF, StallD  out  1 each  hold PC and F/D register
- FlushD  out  1  clear F/D register
- EN_DE, CLR_DE  out  1 each  Decode/Execute register enable / clear
- ForwardA_E, ForwardB_E  out  2 each  00 regfile, 01 from W, 10 from M
- ForwardA_D, ForwardB_D  out  1 each  branch operand from M
- mdu_busy, mdu_done  out  1 each  MDU stall active / final MDU cycle

Behaviour:
- Reset: synchronous on rst_n=0. The FSM goes to IDLE and the counter to 0. While rst_n=0, outputs are forced to:
  - StallF=StallD=FlushD=0
  - EN_DE=0, CLR_DE=1
  - all Forward*=0
  - mdu_busy=mdu_done=0
- Reset mid-MDU aborts the operation to IDLE at the next edge.
- E forwarding, combinational, per operand X in {Rs_E, Rt_E}:
  - 10 if X!=0 && RegWrite_M && WriteReg_M==X;
  - else 01 if X!=0 && RegWrite_W && WriteReg_W==X;
  - else 00. M has priority over W.
- D forwarding: ForwardA_D = Rs_D!=0 && RegWrite_M && WriteReg_M==Rs_D. ForwardB_D is the same for Rt_D.
- lwstall = MemtoReg_E && WriteReg_E!=0 && (WriteReg_E==Rs_D || WriteReg_E==Rt_D).
- branchstall = (Branch_D || Jr_D) && (hit_E || hit_M), where:
  - hit_E = RegWrite_E && WriteReg_E!=0 && WriteReg_E matches a D source;
  - hit_M = MemtoReg_M && WriteReg_M!=0 && WriteReg_M matches a D source;
  - D sources are Rs_D and Rt_D for Branch_D, and Rs_D only for Jr_D.
- MDU FSM states: IDLE, BUSY, DONE. N = DIV_CYCLES if mdu_div_E else MULT_CYCLES, sampled in IDLE. The counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)).
  - IDLE: if mdu_start_E, go to DONE when N==2; otherwise go to BUSY with cnt=N-3. Otherwise stay in IDLE.
  - BUSY: if cnt==0, go to DONE; else cnt decrements.
  - DONE: go to IDLE unconditionally (exactly one cycle). The E instruction advances at the end of DONE, so a following MDU op restarts the sequence from IDLE.
  - The MDU instruction occupies E for exactly N cycles.
- mdu_busy = (IDLE && mdu_start_E) || BUSY.
- mdu_done = (state==DONE).
- Output priority, highest first:
  1. mdu_busy: StallF=StallD=1, EN_DE=0, CLR_DE=0 (E holds its content).
  2. lwstall || branchstall: StallF=StallD=1, EN_DE=0, CLR_DE=1 (bubble into E).
  3. Otherwise: StallF=StallD=0, EN_DE=1, CLR_DE=0.
- EN_DE and CLR_DE are never both 1, since the D/E register gives EN priority over CLR.
- FlushD = (PCSrc_D || J_D || Jr_D) && !StallD. A stall suppresses the flush; the branch re-resolves next cycle.
- Simultaneous MDU stall and load-use: the MDU hold wins, and the load-use bubble is inserted once the MDU reaches DONE, if still valid.
- Register $0 never generates a hazard or a forward.

Test Plan:
- Forwarding: Rs_E=5, RegWrite_M=1, WriteReg_M=5, RegWrite_W=1, WriteReg_W=5 -> ForwardA_E=10. Same with WriteReg_M=6 -> 01. Rs_E=0 -> 00.
- Load-use: MemtoReg_E=1, WriteReg_E=8, Rt_D=8 -> StallF=StallD=1, EN_DE=0, CLR_DE=1 for exactly one cycle; next cycle (load in M) -> EN_DE=1.
- Branch: Branch_D=1, Rs_D=3, RegWrite_E=1, WriteReg_E=3 -> one stall cycle with FlushD=0; next cycle ForwardA_D=1, PCSrc_D=1 -> FlushD=1.
- MULT (MULT_CYCLES=4): mdu_start_E=1, mdu_div_E=0 -> mdu_busy high for 3 cycles with EN_DE=0, CLR_DE=0; then mdu_done=1 and EN_DE=1 in cycle 4; back-to-back DIV then holds 32 cycles.
- Reset mid-DIV: assert rst_n=0 at cycle 10 of a DIV -> EN_DE=0, CLR_DE=1, stalls 0 during reset; after release with mdu_start_E=0 -> IDLE, EN_DE=1.
- $0 destination: MemtoReg_E=1, WriteReg_E=0, Rs_D=0 -> no stall, EN_DE=1.
